led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arbiter.sv | 147 ++++++++++++++
 tb/tb_led_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of a 4-bit LED bank with minimum hold, blink and optional forced release (LED_ARB_TIMEOUT_EN).
// 1-cycle grant latency, all outputs registered; other requesters simply wait while the bank is owned.
module led_arbiter #(
  parameter logic [31:0] HALF_PERIOD = 32'd50_000_000,
  parameter logic [31:0] MIN_HOLD    = 32'd1000,
  parameter logic [31:0] MAX_HOLD    = 32'd500_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] pat_in,
  input  logic [3:0]  blink,
  output logic [3:0]  gnt,
  output logic [3:0]  pl_led,
  output logic        busy
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [31:0] MIN_LAST = MIN_HOLD - 32'd1;
  localparam logic [31:0] HP_LAST  = HALF_PERIOD - 32'd1;

  if (HALF_PERIOD == 32'd0 || MIN_HOLD == 32'd0 || MAX_HOLD < MIN_HOLD) begin : g_bad_cfg
    $error("led_arbiter: illegal parameter set");
  end

  state_t      state, state_nxt;
  logic [3:0]  gnt_nxt, pl_nxt;
  logic        busy_nxt;
  logic [31:0] hold_cnt, hold_nxt;
  logic [31:0] bcnt, bcnt_nxt;
  logic        phase, phase_nxt;
  logic [1:0]  last_owner, last_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [3:0]  excl, excl_nxt;

  logic [3:0]  cand;
  logic [1:0]  idx;
  logic [1:0]  winner;
  logic        found;
  logic [3:0]  own_pat;
  logic        release_req;
  logic        force_rel;

  // Round-robin search from the requester after the last owner; a requester
  // that was forced off is skipped unless it is the only one left.
  always_comb begin
    cand   = req & ~excl;
    idx    = 2'd0;
    winner = last_owner;
    found  = 1'b0;
    if (cand == 4'd0) cand = req;
    for (int k = 0; k < 4; k++) begin
      idx = last_owner + 2'(k) + 2'd1;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign own_pat = pat_in[{owner, 2'b00} +: 4];

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    pl_nxt      = pl_led;
    busy_nxt    = busy;
    hold_nxt    = hold_cnt;
    bcnt_nxt    = bcnt;
    phase_nxt   = phase;
    last_nxt    = last_owner;
    owner_nxt   = owner;
    excl_nxt    = excl;
    release_req = !req[owner] && (hold_cnt >= MIN_LAST);
    force_rel   = 1'b0;
`ifdef LED_ARB_TIMEOUT_EN
    force_rel   = (hold_cnt >= MAX_HOLD - 32'd1) && ((req & ~gnt) != 4'd0);
`endif
    unique case (state)
      IDLE: begin
        gnt_nxt  = 4'd0;
        pl_nxt   = 4'd0;
        busy_nxt = 1'b0;
        if (req != 4'd0) begin
          state_nxt = OWN;
          owner_nxt = winner;
          last_nxt  = winner;
          gnt_nxt   = 4'b0001 << winner;
          busy_nxt  = 1'b1;
          hold_nxt  = 32'd0;
          bcnt_nxt  = 32'd0;
          phase_nxt = 1'b1;
          pl_nxt    = pat_in[{winner, 2'b00} +: 4];
          excl_nxt  = 4'd0;
        end
      end
      OWN: begin
        if (release_req || force_rel) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'd0;
          pl_nxt    = 4'd0;
          busy_nxt  = 1'b0;
          if (force_rel && req[owner]) excl_nxt = gnt;
        end else begin
          if (hold_cnt != 32'hFFFF_FFFF) hold_nxt = hold_cnt + 32'd1;
          if (bcnt == HP_LAST) begin
            bcnt_nxt  = 32'd0;
            phase_nxt = !phase;
          end else begin
            bcnt_nxt = bcnt + 32'd1;
          end
          // Use the post-update phase so each LED half-period is exactly HALF_PERIOD cycles.
          pl_nxt = blink[owner] ? (own_pat & {4{phase_nxt}}) : own_pat;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 4'd0;
      pl_led     <= 4'd0;
      busy       <= 1'b0;
      hold_cnt   <= 32'd0;
      bcnt       <= 32'd0;
      phase      <= 1'b1;
      last_owner <= 2'd3;
      owner      <= 2'd0;
      excl       <= 4'd0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      pl_led     <= pl_nxt;
      busy       <= busy_nxt;
      hold_cnt   <= hold_nxt;
      bcnt       <= bcnt_nxt;
      phase      <= phase_nxt;
      last_owner <= last_nxt;
      owner      <= owner_nxt;
      excl       <= excl_nxt;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed steps for led_arbiter with HALF_PERIOD=4, MIN_HOLD=3, MAX_HOLD=10;
// expected {gnt, pl_led, busy} are queued per step and popped after each edge.
module tb_led_arbiter;

  logic        sys_clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] pat_in;
  logic [3:0]  blink;
  logic [3:0]  gnt;
  logic [3:0]  pl_led;
  logic        busy;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] l;
    logic       b;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    checks   = 0;
  int    failures = 0;

  led_arbiter #(
    .HALF_PERIOD(4),
    .MIN_HOLD   (3),
    .MAX_HOLD   (10)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .req    (req),
    .pat_in (pat_in),
    .blink  (blink),
    .gnt    (gnt),
    .pl_led (pl_led),
    .busy   (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [3:0] g, input logic [3:0] l, input logic b);
    exp_t e;
    e.g = g;
    e.l = l;
    e.b = b;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      t = tq.pop_front();
      assert ({gnt, pl_led, busy} === {e.g, e.l, e.b}) else begin
        failures++;
        $error("FAIL %s observed gnt=%b pl_led=%h busy=%b expected gnt=%b pl_led=%h busy=%b",
               t, gnt, pl_led, busy, e.g, e.l, e.b);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] l, input logic b);
    push_exp(tag, g, l, b);
    @(posedge sys_clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 4'd0;
    pat_in = 16'd0;
    blink  = 4'd0;
    #2;
    push_exp("reset_state", 4'd0, 4'd0, 1'b0);
    check_out();
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    step("idle_no_req", 4'd0, 4'd0, 1'b0);

    // Single requester: 1-cycle latency, early drop held to MIN_HOLD
    req    = 4'b0001;
    pat_in = 16'h000A;
    step("grant_latency", 4'b0001, 4'hA, 1'b1);
    req = 4'b0000;
    step("min_hold_1", 4'b0001, 4'hA, 1'b1);
    step("min_hold_2", 4'b0001, 4'hA, 1'b1);
    step("min_hold_release", 4'd0, 4'd0, 1'b0);
    step("idle_after_release", 4'd0, 4'd0, 1'b0);

    // Pattern tracking and non-owner request changes
    req    = 4'b0001;
    pat_in = 16'h4325;
    step("grant_owner0", 4'b0001, 4'h5, 1'b1);
    pat_in = 16'h4326;
    req    = 4'b0111;
    step("pat_track", 4'b0001, 4'h6, 1'b1);
    req = 4'b1101;
    step("nonowner_req_1", 4'b0001, 4'h6, 1'b1);
    step("nonowner_req_2", 4'b0001, 4'h6, 1'b1);
    req = 4'b0110;
    step("owner_drop", 4'd0, 4'd0, 1'b0);
    step("rr_next_owner1", 4'b0010, 4'h2, 1'b1);
    req = 4'b0000;
    step("owner1_hold_1", 4'b0010, 4'h2, 1'b1);
    step("owner1_hold_2", 4'b0010, 4'h2, 1'b1);
    step("owner1_release", 4'd0, 4'd0, 1'b0);

    // Blink with HALF_PERIOD=4
    req    = 4'b0100;
    pat_in = 16'h0F00;
    blink  = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      step("blink", 4'b0100, (((k / 4) % 2) == 0) ? 4'hF : 4'h0, 1'b1);
    end
    req = 4'b0000;
    step("blink_release", 4'd0, 4'd0, 1'b0);
    blink = 4'b0000;

    // Asynchronous reset mid-grant
    req    = 4'b1000;
    pat_in = 16'h7000;
    step("grant_owner3", 4'b1000, 4'h7, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 4'd0, 4'd0, 1'b0);
    check_out();
    req    = 4'b1111;
    pat_in = 16'h4321;
    @(posedge sys_clk);
    #1;
    push_exp("reset_held", 4'd0, 4'd0, 1'b0);
    check_out();
    rst_n = 1'b1;

    // Full round robin after reset, one idle cycle between owners
    for (int i = 0; i < 4; i++) begin
      req = 4'b1111;
      step("rr_grant", 4'(1 << i), 4'(i + 1), 1'b1);
      step("rr_hold_1", 4'(1 << i), 4'(i + 1), 1'b1);
      step("rr_hold_2", 4'(1 << i), 4'(i + 1), 1'b1);
      req = 4'b1111 & ~4'(1 << i);
      step("rr_gap", 4'd0, 4'd0, 1'b0);
    end

    // Timeout with two persistent requesters
    req    = 4'b0011;
    pat_in = 16'h00C5;
    step("to_grant", 4'b0001, 4'h5, 1'b1);
    for (int k = 1; k < 10; k++) begin
      step("to_hold", 4'b0001, 4'h5, 1'b1);
    end
`ifdef LED_ARB_TIMEOUT_EN
    step("to_forced_release", 4'd0, 4'd0, 1'b0);
    step("to_next_owner", 4'b0010, 4'hC, 1'b1);
`else
    for (int k = 0; k < 10; k++) begin
      step("no_timeout_hold", 4'b0001, 4'h5, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
